// File: rtl/pixel_frame_responder.sv
// Memory-side responder for the median filter datapath.
// Holds the binary input frame loaded as a serial raster stream and answers
// window reads with a fixed 2-cycle latency. It captures median write-backs
// into an output frame, then streams that frame out as packed bytes.
module pixel_frame_responder #(
  parameter int unsigned WINDOW_SIZE  = 3,
  parameter int unsigned IMAGE_WIDTH  = 240,
  parameter int unsigned IMAGE_HEIGHT = 180,
  parameter int unsigned ADDR_WIDTH   = 16
) (
  input  logic       clk,
  input  logic       reset,
  // serial frame load
  input  logic       loadValid,
  input  logic       loadData,
  output logic       loadReady,
  output logic       frameReady,
  // filter window reads
  input  logic [7:0] rdX,
  input  logic [7:0] rdY,
  output logic       rdData,
  // median write-backs
  input  logic       wrEn,
  input  logic [7:0] wrX,
  input  logic [7:0] wrY,
  input  logic       wrData,
  output logic       wrError,
  // packed output stream
  output logic       outValid,
  input  logic       outReady,
  output logic [7:0] outByte,
  output logic       outLast
);

  localparam int unsigned NumPix   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned NumWr    = (IMAGE_WIDTH - WINDOW_SIZE + 1) *
                                     (IMAGE_HEIGHT - WINDOW_SIZE + 1);
  localparam int unsigned NumBytes = (NumPix + 7) / 8;
  localparam int unsigned PixAw    = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam int unsigned ByteAw   = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [ADDR_WIDTH-1:0] LastPix   = ADDR_WIDTH'(NumPix - 1);
  localparam logic [ADDR_WIDTH-1:0] LastWr    = ADDR_WIDTH'(NumWr - 1);
  localparam logic [ADDR_WIDTH-1:0] LastByte  = ADDR_WIDTH'(NumBytes - 1);
  localparam logic [ADDR_WIDTH-1:0] TotBytes  = ADDR_WIDTH'(NumBytes);
  localparam logic [ADDR_WIDTH-1:0] AddrOne   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    StLoad,
    StServe,
    StDrain
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Input frame: contents are don't-care after reset, so no reset on the array.
  logic                  r_in_mem [NumPix];
  // Output frame packed eight pixels per word, LSB = lowest linear index.
  logic [7:0]            r_out_mem [NumBytes];

  logic [ADDR_WIDTH-1:0] r_load_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_drain_cnt;

  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic                  r_rd_ok;
  logic                  r_rd_data;

  logic                  r_wr_error;
  logic                  r_out_valid;
  logic [7:0]            r_out_byte;
  logic                  r_out_last;

  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic                  w_wr_ok;
  logic [ByteAw-1:0]     w_wr_word;
  logic                  w_load_fire;
  logic                  w_load_done;
  logic                  w_wr_fire;
  logic                  w_wr_done;
  logic                  w_wr_bad;
  logic                  w_xfer;
  logic                  w_byte_load;
  logic                  w_drain_done;
  logic                  w_unused;

  function automatic logic [ADDR_WIDTH-1:0] lin_idx(input logic [7:0] x, input logic [7:0] y);
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(IMAGE_WIDTH) + ADDR_WIDTH'(x);
  endfunction

  function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
    return (32'(x) < IMAGE_WIDTH) && (32'(y) < IMAGE_HEIGHT);
  endfunction

  assign w_rd_idx  = lin_idx(rdX, rdY);
  assign w_rd_ok   = in_range(rdX, rdY);
  assign w_wr_idx  = lin_idx(wrX, wrY);
  assign w_wr_ok   = in_range(wrX, wrY);
  assign w_wr_word = ByteAw'(w_wr_idx >> 3);

  assign w_load_fire  = (r_state == StLoad) && loadValid;
  assign w_load_done  = w_load_fire && (r_load_cnt == LastPix);
  assign w_wr_fire    = (r_state == StServe) && wrEn && w_wr_ok;
  assign w_wr_done    = w_wr_fire && (r_wr_cnt == LastWr);
  assign w_wr_bad     = wrEn && ((r_state != StServe) || !w_wr_ok);
  assign w_xfer       = r_out_valid && outReady;
  // Fetch the next word whenever the output register is empty or being emptied.
  assign w_byte_load  = (r_state == StDrain) && (r_drain_cnt < TotBytes) &&
                        (!r_out_valid || outReady);
  assign w_drain_done = (r_state == StDrain) && w_xfer && r_out_last;

  // Only the low bits of the wide counters address the arrays.
  assign w_unused = ^{w_rd_idx, r_rd_idx, r_load_cnt, r_drain_cnt, w_wr_idx};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    loadReady    = 1'b0;
    frameReady   = 1'b0;
    unique case (r_state)
      StLoad: begin
        loadReady = 1'b1;
        if (w_load_done) w_state_next = StServe;
      end
      StServe: begin
        frameReady = 1'b1;
        if (w_wr_done) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_drain_done) w_state_next = StLoad;
      end
      default: w_state_next = StLoad;
    endcase
  end

  // Load pixel counter; wraps to zero on the final pixel of the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_cnt <= '0;
    end else if (w_load_fire) begin
      r_load_cnt <= w_load_done ? '0 : r_load_cnt + AddrOne;
    end
  end

  // Input frame storage written by the load stream.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_in_mem[PixAw'(r_load_cnt)] <= loadData;
    end
  end

  // Two-stage read pipeline: index/range, then memory bit (0 when out of range).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_idx  <= '0;
      r_rd_ok   <= 1'b0;
      r_rd_data <= 1'b0;
    end else begin
      r_rd_idx  <= w_rd_idx;
      r_rd_ok   <= w_rd_ok;
      r_rd_data <= r_rd_ok ? r_in_mem[PixAw'(r_rd_idx)] : 1'b0;
    end
  end

  // Accepted median counter; duplicates count, out-of-range writes do not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt <= '0;
    end else if (w_wr_fire) begin
      r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + AddrOne;
    end
  end

  // Sticky flag for writes that are out of range or arrive outside SERVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_error <= 1'b0;
    end else if (w_wr_bad) begin
      r_wr_error <= 1'b1;
    end
  end

  // Output frame: medians land bit-wise; each word is zeroed as it is drained,
  // so the frame is already clear once the last byte leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_mem <= '{default: '0};
    end else begin
      if (w_wr_fire) begin
        r_out_mem[w_wr_word][w_wr_idx[2:0]] <= wrData;
      end
      if (w_byte_load) begin
        r_out_mem[ByteAw'(r_drain_cnt)] <= '0;
      end
    end
  end

  // Registered output byte stage with valid/ready hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_byte_load) begin
        r_out_byte  <= r_out_mem[ByteAw'(r_drain_cnt)];
        r_out_valid <= 1'b1;
        r_out_last  <= (r_drain_cnt == LastByte);
        r_drain_cnt <= r_drain_cnt + AddrOne;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_drain_done) begin
        r_drain_cnt <= '0;
      end
    end
  end

  assign rdData   = r_rd_data;
  assign wrError  = r_wr_error;
  assign outValid = r_out_valid;
  assign outByte  = r_out_byte;
  assign outLast  = r_out_last;

endmodule

// File: tb/tb_pixel_frame_responder.sv
// Directed bench for pixel_frame_responder on a reduced 20x13 frame.
// Expected read bits and output bytes come from a bench-side frame model and
// are queued at stimulus time, then popped when the DUT presents data.
module tb_pixel_frame_responder;

  localparam int unsigned K  = 3;
  localparam int unsigned W  = 20;
  localparam int unsigned H  = 13;
  localparam int unsigned AW = 16;
  localparam int NumPix   = W * H;
  localparam int NumWr    = (W - K + 1) * (H - K + 1);
  localparam int NumBytes = (NumPix + 7) / 8;

  logic       clk;
  logic       reset;
  logic       loadValid;
  logic       loadData;
  logic       loadReady;
  logic       frameReady;
  logic [7:0] rdX;
  logic [7:0] rdY;
  logic       rdData;
  logic       wrEn;
  logic [7:0] wrX;
  logic [7:0] wrY;
  logic       wrData;
  logic       wrError;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;
  logic       outLast;

  pixel_frame_responder #(
    .WINDOW_SIZE (K),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .loadValid (loadValid),
    .loadData  (loadData),
    .loadReady (loadReady),
    .frameReady(frameReady),
    .rdX       (rdX),
    .rdY       (rdY),
    .rdData    (rdData),
    .wrEn      (wrEn),
    .wrX       (wrX),
    .wrY       (wrY),
    .wrData    (wrData),
    .wrError   (wrError),
    .outValid  (outValid),
    .outReady  (outReady),
    .outByte   (outByte),
    .outLast   (outLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit         in_model  [NumPix];
  bit         out_model [NumBytes*8];
  logic [7:0] exp_q [$];
  logic       rd_q  [$];

  int rx [8] = '{5, 6, 20, 0, 19, 0, 3, 255};
  int ry [8] = '{7, 7, 0, 13, 12, 0, 4, 255};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pat(input int sel, input int x, input int y);
    if (sel == 0) return bit'((x ^ y) & 1);
    return ((x + y) % 3) == 0;
  endfunction

  function automatic bit med(input int x, input int y);
    return ((x + 2 * y) % 3) != 0;
  endfunction

  function automatic logic exp_rd(input int x, input int y);
    if (x < W && y < H) return in_model[y * W + x];
    return 1'b0;
  endfunction

  task automatic load_frame(input int sel);
    for (int i = 0; i < NumPix; i++) begin
      int x = i % W;
      int y = i / W;
      if (i % 37 == 5) begin
        loadValid = 1'b0;
        loadData  = 1'b1;
        step();
      end
      if (i == NumPix - 1) chk("load_ready_before_last", loadReady, 1);
      loadValid   = 1'b1;
      loadData    = pat(sel, x, y);
      in_model[i] = pat(sel, x, y);
      step();
    end
    loadValid = 1'b0;
    loadData  = 1'b0;
    chk("load_ready_after_load", loadReady, 0);
    chk("frame_ready_after_load", frameReady, 1);
  endtask

  task automatic rd_seq();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        rdX = 8'(rx[i]);
        rdY = 8'(ry[i]);
        rd_q.push_back(exp_rd(rx[i], ry[i]));
      end
      step();
      if (i >= 1) begin
        logic e;
        e = rd_q.pop_front();
        chk($sformatf("rd_%0d_%0d", rx[i-1], ry[i-1]), rdData, e);
      end
    end
  endtask

  task automatic write_px(input int x, input int y, input bit v);
    wrEn   = 1'b1;
    wrX    = 8'(x);
    wrY    = 8'(y);
    wrData = v;
    step();
    wrEn   = 1'b0;
  endtask

  task automatic write_medians(input bit dup);
    int cnt  = 0;
    bit done = 0;
    if (dup) begin
      write_px(1, 1, 1'b0);
      out_model[W + 1] = 1'b0;
      cnt = 1;
      chk("frame_ready_after_dup", frameReady, 1);
    end
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        if (!done) begin
          if (cnt == NumWr - 1) chk("frame_ready_before_final_write", frameReady, 1);
          write_px(x, y, med(x, y));
          out_model[y * W + x] = med(x, y);
          cnt++;
          if (cnt == NumWr) begin
            done = 1;
            chk("frame_ready_in_drain", frameReady, 0);
            chk("load_ready_in_drain", loadReady, 0);
            chk("out_valid_drain_entry", outValid, 0);
          end
        end
      end
    end
    chk("drain_entered", done, 1);
    if (dup) begin
      // Write during DRAIN must not reach the output frame.
      write_px(W - 2, H - 2, 1'b1);
      chk("out_valid_after_entry", outValid, 1);
      chk("wr_error_drain_write", wrError, 1);
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int b = 0; b < NumBytes; b++) begin
      logic [7:0] v;
      for (int j = 0; j < 8; j++) v[j] = out_model[b * 8 + j];
      exp_q.push_back(v);
    end
  endtask

  task automatic drain(input int max_x, input bit stall);
    int         cyc = 0;
    int         xf  = 0;
    int         st  = 0;
    logic [7:0] held;
    logic [7:0] e;
    bit         rdy;
    held = '0;
    while (xf < max_x && cyc < 4000) begin
      if (stall && xf == 10 && st < 5) begin
        rdy = 1'b0;
        if (st == 0) held = outByte;
        else chk("stall_byte_hold", outByte, held);
        chk("stall_valid_hold", outValid, 1);
        st++;
      end else begin
        rdy = (cyc % 3) != 1;
      end
      outReady = rdy;
      if (outValid && rdy) begin
        e = exp_q.pop_front();
        chk($sformatf("byte_%0d", xf), outByte, e);
        chk($sformatf("last_%0d", xf), outLast, exp_q.size() == 0);
        xf++;
      end
      step();
      cyc++;
    end
    outReady = 1'b0;
    chk("drain_transfer_count", xf, max_x);
  endtask

  task automatic post_drain();
    int w = 0;
    while (!loadReady && w < 50) begin
      step();
      w++;
    end
    chk("load_ready_after_drain", loadReady, 1);
    chk("out_valid_after_drain", outValid, 0);
    chk("frame_ready_after_drain", frameReady, 0);
    chk("wr_error_sticky", wrError, 1);
    for (int i = 0; i < NumBytes * 8; i++) out_model[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    loadValid = 1'b0;
    loadData  = 1'b0;
    rdX       = '0;
    rdY       = '0;
    wrEn      = 1'b0;
    wrX       = '0;
    wrY       = '0;
    wrData    = 1'b0;
    outReady  = 1'b0;
    step();
    step();
    chk("rst_load_ready", loadReady, 1);
    chk("rst_frame_ready", frameReady, 0);
    chk("rst_out_valid", outValid, 0);
    chk("rst_out_byte", outByte, 0);
    chk("rst_out_last", outLast, 0);
    chk("rst_wr_error", wrError, 0);
    chk("rst_rd_data", rdData, 0);
    reset = 1'b0;
    step();

    // Frame 1: checkerboard, reads, bad writes, full sweep, drain with stall.
    load_frame(0);
    chk("wr_error_clean", wrError, 0);
    loadValid = 1'b1;  // ignored outside LOAD; would flip pixel (0,0)
    loadData  = 1'b1;
    step();
    loadValid = 1'b0;
    loadData  = 1'b0;
    rd_seq();
    write_px(W + 10, 3, 1'b1);
    chk("wr_error_oob_x", wrError, 1);
    chk("frame_ready_after_oob", frameReady, 1);
    write_px(3, H, 1'b1);
    write_medians(0);
    build_exp();
    drain(NumBytes, 1'b1);
    post_drain();

    // Frame 2: other pattern, abort by reset mid-drain.
    load_frame(1);
    chk("wr_error_next_frame", wrError, 1);
    rd_seq();
    write_medians(0);
    build_exp();
    drain(5, 1'b0);
    reset = 1'b1;
    step();
    chk("abort_load_ready", loadReady, 1);
    chk("abort_out_valid", outValid, 0);
    chk("abort_frame_ready", frameReady, 0);
    chk("abort_wr_error", wrError, 0);
    chk("abort_out_last", outLast, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NumBytes * 8; i++) out_model[i] = 1'b0;
    step();

    // Frame 3: fresh load, duplicate write counted, full drain.
    load_frame(0);
    rd_seq();
    write_medians(1);
    build_exp();
    drain(NumBytes, 1'b0);
    post_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_responder.md
Name: pixel_frame_responder

Overview:
- Memory-side responder for the median filter datapath.
- Stores the binary input frame, loaded as a serial raster stream.
- Answers filter window reads (x,y) with a fixed 2-cycle latency. This latency matches the filter's two-stage dataValid delay.
- Captures median write-backs into an output frame, then streams that frame out as packed bytes over a valid/ready handshake.

Parameters:
- WINDOW_SIZE, 3, filter window edge; sets the expected write count.
- IMAGE_WIDTH, 240, pixels per row (≤256).
- IMAGE_HEIGHT, 180, rows per frame (≤256).
- ADDR_WIDTH, 16, linear pixel index width; must satisfy 2^ADDR_WIDTH ≥ IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- loadValid  in  1  loadData is valid this cycle
- loadData  in  1  input pixel, raster order (x fastest)
- loadReady  out  1  block accepts load pixels (LOAD state)
- frameReady  out  1  input frame fully loaded; filter may be started
- rdX  in  8  read column (filter xAddressOut)
- rdY  in  8  read row (filter yAddressOut)
- rdData  out  1  pixel at (rdX,rdY) sampled 2 cycles earlier
- wrEn  in  1  median write strobe (filter writeEnable)
- wrX  in  8  write column (filter xMedianAddress)
- wrY  in  8  write row (filter yMedianAddress)
- wrData  in  1  median pixel (filter dataOut)
- wrError  out  1  sticky: an out-of-range write, or a write outside SERVE, was attempted
- outValid  out  1  outByte valid
- outReady  in  1  consumer accepts outByte
- outByte  out  8  eight output pixels, LSB = lowest linear index
- outLast  out  1  qualifies the final byte of the frame

Behaviour:
- Reset values:
  - State LOAD; loadReady=1; all other outputs 0.
  - Load/write/drain counters cleared; output frame memory cleared to 0.
  - Input memory contents are undefined.
- Linear index = y*IMAGE_WIDTH + x, computed at ADDR_WIDTH with no truncation. A coordinate is in range iff x<IMAGE_WIDTH and y<IMAGE_HEIGHT.
- State LOAD:
  - loadReady=1. Each cycle with loadValid=1 writes loadData at the load counter, then increments the counter.
  - When pixel IMAGE_WIDTH*IMAGE_HEIGHT-1 is accepted: counter clears, go to SERVE, and frameReady=1 from the next cycle.
  - loadValid while loadReady=0 is ignored.
- State SERVE:
  - frameReady=1. Writes with wrEn=1 and in-range (wrX,wrY) store wrData into the output memory and increment the write counter.
  - An out-of-range write is dropped, sets wrError, and does not count.
  - When the counter reaches (IMAGE_WIDTH-WINDOW_SIZE+1)*(IMAGE_HEIGHT-WINDOW_SIZE+1), go to DRAIN; frameReady drops the next cycle.
  - A duplicate-address write overwrites the stored value and still counts.
- Read pipeline (active in every state, not gated):
  - Stage 1 registers the index and the range flag.
  - Stage 2 registers the memory bit into rdData; an out-of-range read gives rdData=0.
  - rdX/rdY at edge N produce rdData after edge N+2. Back-to-back reads every cycle are supported.
- Output memory placement: each median is stored exactly at (wrX,wrY). Border pixels never written remain 0.
- State DRAIN:
  - Byte k holds output pixels 8k..8k+7; pixels at or beyond W*H are padded with 0.
  - Total bytes = ceil(W*H/8); 5400 at the defaults.
  - outByte is registered; outValid asserts one cycle after entering DRAIN.
  - A transfer occurs when outValid&&outReady; the next byte is presented on the following cycle, with no bubble if outReady is held high.
  - While outValid=1 and outReady=0, outByte and outLast hold stable.
  - outLast=1 only with the final byte. After it transfers: output memory cleared (may take multiple cycles; loadReady stays 0 until clearing completes), then state LOAD.
- wrEn during LOAD or DRAIN: ignored and sets wrError. wrError clears only on reset.
- Reset mid-operation: any state aborts immediately to LOAD; a partial frame is discarded.

Test Plan:
- Load a 240x180 checkerboard (pixel = x^y bit 0) → loadReady falls after 43200 accepts. frameReady=1 the cycle after.
- After load, read (5,7) then (6,7) on consecutive cycles → rdData=0 two edges after (5,7), then 1 on the next cycle. Read (240,0) → rdData=0.
- Write all 238x178=42364 in-range medians, value 1 → DRAIN entered and frameReady=0.
  - Byte 0 = 0x00: row 0 is border.
  - Byte 30 (pixels 240–247) = 0xFE: x=0 is border, x=1..7 written.
- During DRAIN, hold outReady=0 for 5 cycles mid-frame → outByte unchanged. Then toggle outReady → exactly 5400 transfers, outLast only on the 5400th.
- In SERVE, write (250,3) with wrEn=1 → wrError=1 and the write counter is unchanged. wrError stays 1 across the next frame until reset.
- Assert reset in the middle of DRAIN → state LOAD, outValid=0, loadReady=1. A fresh load completes normally.
